// File: rtl/sram_port_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: default widths, FSM state
// encoding and requester IDs.
package sram_port_arb_pkg;

    localparam int SRAM_ADDR_W = 12;
    localparam int SRAM_DATA_W = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_GNT_I = 1'b0,
        ARB_GNT_D = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/sram_port_arb_rr2.sv
// Two-way round-robin picker. Bit 0 is the I requester, bit 1 the D
// requester. On a tie the requester that did not win last time is chosen.
// Purely combinational so it can be reused in front of other shared ports.
module arb_rr2
    import sram_port_arb_pkg::*;
(
    input  logic [1:0] req,
    input  arb_gnt_e   last,
    output logic [1:0] gnt
);

    // One-hot grant from the request pair and the previous winner
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == ARB_GNT_I) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_port_arb.sv
// Shares one byte-enabled single-port SRAM port between the CPU instruction
// and data buses with round-robin arbitration.
//
// Handshake: a requester raises valid and holds addr/wdata/wstrb until the
// cycle its ready is 1; that cycle consumes the request, and in the next
// cycle the requester either drops valid or presents a new request. ready
// is a one-cycle pulse for reads and writes alike, and rdata is meaningful
// only while ready is 1.
module sram_port_arb
    import sram_port_arb_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W - 2,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,

    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,

    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,

    output arb_state_e          dbg_state
);

    arb_state_e state, next_state;
    arb_gnt_e   gnt, last, win_id;
    logic [1:0] req, win;
    logic       issue;

    // Candidates for issue this cycle: in RESP the granted requester is
    // still holding its consumed request, so only the other side may issue.
    // Nothing is issued while reset is held.
    always_comb begin
        req = 2'b00;
        if (!rst) begin
            if (state == ARB_IDLE) begin
                req = {d_valid, i_valid};
            end else if (gnt == ARB_GNT_I) begin
                req = {d_valid, 1'b0};
            end else begin
                req = {1'b0, i_valid};
            end
        end
    end

    arb_rr2 u_pick (
        .req  (req),
        .last (last),
        .gnt  (win)
    );

    // Next state and memory-port drive from the winning requester
    always_comb begin
        issue      = |win;
        win_id     = win[1] ? ARB_GNT_D : ARB_GNT_I;
        next_state = issue ? ARB_RESP : ARB_IDLE;
        m_valid    = issue;
        m_addr     = win[1] ? d_addr  : i_addr;
        m_wdata    = win[1] ? d_wdata : i_wdata;
        m_wstrb    = '0;
        if (issue) begin
            m_wstrb = win[1] ? d_wstrb : i_wstrb;
        end
    end

    // State, response owner and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            gnt   <= ARB_GNT_I;
            last  <= ARB_GNT_I;
        end else begin
            state <= next_state;
            if (issue) begin
                gnt  <= win_id;
                last <= win_id;
            end
        end
    end

    // The response cycle belongs to exactly one requester, so at most one
    // ready is high. Read data goes to both buses unconditionally.
    assign i_ready   = (state == ARB_RESP) && (gnt == ARB_GNT_I);
    assign d_ready   = (state == ARB_RESP) && (gnt == ARB_GNT_D);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;
    assign dbg_state = state;

endmodule
